pipe_muldiv_ctrl: RTL

- Sequencer for multiply/divide operations and owner of the architectural HI/LO registers in the pipelined MIPS CPU.
- Accepts MULT/MULTU/DIV/DIVU from execute stage; runs multiply with fixed latency and divide as 32-step restoring iteration.
- Raises busy so the hazard unit stalls MFHI/MFLO/MTHI/MTLO and further mul/div; honours memory waitrequest freeze like the rest of the pipeline.

---
 rtl/pipe_muldiv_ctrl_if.sv | 26 ++
 rtl/pipe_muldiv_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_muldiv_ctrl_if.sv
// Execute-stage handshake for the mul/div sequencer: issue, MTHI/MTLO writes,
// memory freeze, and the HI/LO / busy / done results.
interface pipe_muldiv_ctrl_if;
  logic        waitrequest;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output waitrequest, start, op, src_a, src_b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  waitrequest, start, op, src_a, src_b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/pipe_muldiv_ctrl.sv
// Mul/div sequencer and HI/LO owner: fixed-latency multiply, 32-step restoring divide.
// Optional MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| finish one edge after accept.
module pipe_muldiv_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_STEPS   = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_muldiv_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | accepting start / MTHI / MTLO
  // MUL   | counting down the multiply latency
  // DIV   | one restoring-division step per edge
  // FIX   | apply signs, write HI/LO
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic        bzero_q, bzero_d, done_q, done_d;

  logic        op_div, op_sgn;
  logic [31:0] mag_a, mag_b;
  logic [32:0] shifted, trial;
  logic [63:0] ext_a, ext_b, prod;

  assign op_div  = bus.op[1];
  assign op_sgn  = ~bus.op[0];
  assign mag_a   = (op_sgn && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
  assign mag_b   = (op_sgn && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, b_q};
  assign ext_a   = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b   = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod    = ext_a * ext_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    done_d  = done_q;
    if (!bus.waitrequest) begin
      done_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_d     = bus.src_a;
            sgn_d   = op_sgn;
            qneg_d  = op_sgn & op_div & (bus.src_a[31] ^ bus.src_b[31]);
            rneg_d  = op_sgn & op_div & bus.src_a[31];
            bzero_d = (bus.src_b == 32'd0);
            if (op_div) begin
              // quo_q doubles as the dividend shift register during iteration
              b_d     = mag_b;
              rem_d   = 32'd0;
              quo_d   = mag_a;
              cnt_d   = 5'(DIV_STEPS - 1);
              state_d = S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
              if (mag_b != 32'd0 && mag_a < mag_b) begin
                quo_d   = 32'd0;
                rem_d   = mag_a;
                state_d = S_FIX;
              end
`endif
            end else begin
              b_d     = bus.src_b;
              cnt_d   = 5'(MUL_LATENCY - 1);
              state_d = S_MUL;
            end
          end else begin
            if (bus.mthi) hi_d = bus.wdata;
            if (bus.mtlo) lo_d = bus.wdata;
          end
        end
        S_MUL: begin
          if (cnt_q == 5'd0) begin
            {hi_d, lo_d} = prod;
            done_d       = 1'b1;
            state_d      = S_IDLE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_DIV: begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          if (cnt_q == 5'd0) state_d = S_FIX;
          else cnt_d = cnt_q - 5'd1;
        end
        S_FIX: begin
          // divide by zero bypasses sign fix-up: all-ones quotient, raw dividend
          if (bzero_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_q;
          end else begin
            lo_d = qneg_q ? (32'd0 - quo_q) : quo_q;
            hi_d = rneg_q ? (32'd0 - rem_q) : rem_q;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
